alu_issue: RTL and testbench
============================

# alu_issue

Instruction issue and writeback stage that sits directly upstream of the 4-bit ALU in the example CPU. It accepts one instruction per valid/ready handshake and reads its operands from a 4-entry register file. It drives the ALU's combinational operand and opcode inputs from registers, then writes the ALU result back to the register file and latches the zero and carry flags. It also executes load-immediate instructions without using the ALU.

## Interface
- WIDTH, 4, datapath width; must match the ALU's WIDTH (≥2).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  instruction offered.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_instr  input  10  [9]=ldi, [8:6]=op, [5:4]=dst, [3:2]=src_a, [1:0]=src_b.
- in_imm  input  WIDTH  immediate, used only when ldi=1.
- alu_a  output  WIDTH  registered ALU operand a.
- alu_b  output  WIDTH  registered ALU operand b.
- alu_op  output  3  registered ALU opcode.
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- done  output  1  one-cycle pulse; writeback completed.
- flag_zero  output  1  latched zero flag.
- flag_carry  output  1  latched carry flag.
- dbg_addr  input  2  register file debug read address.
- dbg_data  output  WIDTH  combinational read of rf[dbg_addr].

## Operation
- State is rf[0..3] (WIDTH bits each), flag_zero, flag_carry, and an FSM with two states, IDLE and EXEC.
- Reset values: all rf entries = 0; flag_zero = 0; flag_carry = 0; alu_a = alu_b = 0; alu_op = 3'b000; done = 0; FSM = IDLE, so in_ready = 1.
- **IDLE:**
  - in_ready = 1.
  - An accept occurs on a rising edge with in_valid & in_ready. On accept, latch ldi, dst, and in_imm, then go to EXEC.
  - If ldi = 0, also load alu_a ← rf[src_a], alu_b ← rf[src_b], alu_op ← op, using register values as they are at the accept edge.
  - If ldi = 1, alu_a, alu_b and alu_op hold their previous values.
- **EXEC:**
  - in_ready = 0. The ALU result settles combinationally during this cycle.
  - On the next edge, unconditionally return to IDLE and assert done for one cycle.
  - If ldi = 0: rf[dst] ← alu_result, flag_zero ← alu_zero, flag_carry ← alu_carry.
  - If ldi = 1: rf[dst] ← imm, flag_zero ← (imm == 0), flag_carry unchanged.
- Opcodes pass through to the ALU unmodified: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR. This block does no arithmetic.
- dst equal to src_a or src_b is legal. Operands were captured at accept, so no hazard exists.
- in_valid while in EXEC is ignored. The offer stays pending until the next IDLE cycle.
- dbg_data reflects writebacks from the cycle after the writeback edge.

## Timing
- Accept at edge E0. alu_a, alu_b and alu_op are valid from E0 until the next ldi=0 accept.
- Writeback and flag update occur at edge E1 = E0+1. done is high for the cycle between E1 and E2.
- The next accept is possible at E1+1 (edge E2). Sustained throughput is one instruction per 2 cycles with in_valid held high.
- An instruction accepted at E2 reads rf values already updated at E1. No bypass is needed.
- Reset asserted in EXEC aborts the instruction: no writeback, done = 0, all state returns to reset values immediately (asynchronously).
- Reset asserted in the same cycle as in_valid: no accept occurs.

## Test plan
- Reset, then LDI r0 ← 5, LDI r1 ← 3, then ADD r2 = r0 + r1 → rf[2] = 8, flag_zero = 0, flag_carry = 0, done pulses once per instruction, alu_a = 5 and alu_b = 3 during EXEC.
- With rf[2] = 8, ADD r3 = r2 + r2 → rf[3] = 0, flag_zero = 1, flag_carry = 1. Then LDI r0 ← 0 → flag_zero = 1 and flag_carry stays 1.
- With rf[1] = 3 and rf[0] = 5, SUB r1 = r1 − r0 → rf[1] = 4'hE, flag_carry = 1, flag_zero = 0. Then SHL r0 = r0 (5) → rf[0] = 4'hA, flag_carry = 0.
- Hold in_valid high for 4 back-to-back ADDs → in_ready toggles 1,0,1,0. Accepts occur exactly every 2 cycles. 4 done pulses. Each instruction sees the prior result (r0 = r0 + r1 with r0 = 1 and r1 = 1 gives 2, 3, 4, 5).
- Assert rst during EXEC of ADD r2 = 5 + 3 → rf[2] stays 0, done stays 0, in_ready = 1 and alu_op = 000 immediately, without waiting for a clock edge.
- Sweep dbg_addr 0..3 after a known sequence → dbg_data matches the expected rf contents. Offering in_valid during EXEC does not cause a double accept.

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction-offer channel into the ALU issue stage.
// Handshake: a transfer happens on a rising clk edge where in_valid and in_ready are both high;
// the master holds in_instr/in_imm stable while in_valid is high, and in_ready does not depend on in_valid.
interface alu_issue_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_instr;
  logic [WIDTH-1:0] in_imm;

  modport master (output in_valid, in_instr, in_imm, input in_ready);
  modport slave  (input in_valid, in_instr, in_imm, output in_ready);
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the combinational ALU: reads a 4-entry register file,
// drives registered operands to the ALU, then writes the result and flags back one cycle later.
module alu_issue #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_if.slave       in_if,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_carry,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             writeback;
  logic             ldi_q;
  logic [1:0]       dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] rf [4];

  logic       in_ldi;
  logic [2:0] in_op;
  logic [1:0] in_dst;
  logic [1:0] in_src_a;
  logic [1:0] in_src_b;

  assign {in_ldi, in_op, in_dst, in_src_a, in_src_b} = in_if.in_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    writeback      = 1'b0;
    in_if.in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_if.in_ready = 1'b1;
        if (in_if.in_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        writeback  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured at accept, so a dst that aliases a source needs no hazard handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldi_q      <= 1'b0;
      dst_q      <= 2'd0;
      imm_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'b000;
      done       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      done <= writeback;
      if (accept) begin
        ldi_q <= in_ldi;
        dst_q <= in_dst;
        imm_q <= in_if.in_imm;
        if (!in_ldi) begin
          alu_a  <= rf[in_src_a];
          alu_b  <= rf[in_src_b];
          alu_op <= in_op;
        end
      end
      if (writeback) begin
        if (ldi_q) begin
          rf[dst_q] <= imm_q;
          flag_zero <= (imm_q == '0);
        end else begin
          rf[dst_q]  <= alu_result;
          flag_zero  <= alu_zero;
          flag_carry <= alu_carry;
        end
      end
    end
  end

  assign dbg_data  = rf[dbg_addr];
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural 4-bit ALU on the operand outputs, register-file/flag model,
// expected writebacks queued at drive time and compared when done pulses.
module tb_alu_issue;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_op;
  logic             alu_zero, alu_carry;
  logic             done, flag_zero, flag_carry, dbg_state;
  logic [1:0]       dbg_addr = 2'd0;
  logic [WIDTH-1:0] dbg_data;

  alu_issue_if #(.WIDTH(WIDTH)) in_if ();

  alu_issue #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- ALU (returns {carry, result}) ----------------
  function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a[3], a << 1};
      default: return {a[0], a >> 1};
    endcase
  endfunction

  logic [4:0] alu_out;
  assign alu_out    = alu_fn(alu_op, alu_a, alu_b);
  assign alu_result = alu_out[3:0];
  assign alu_carry  = alu_out[4];
  assign alu_zero   = (alu_out[3:0] == 4'd0);

  // ---------------- model + scoreboard ----------------
  logic [3:0] m_rf [4];
  logic       m_z, m_c;
  logic [7:0] exp_q[$];   // {dst[1:0], data[3:0], zero, carry}
  logic [7:0] mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  task automatic push_exp(input logic ldi, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm);
    logic [4:0] r;
    if (ldi) begin
      m_rf[dst] = imm;
      m_z       = (imm == 4'd0);
    end else begin
      r         = alu_fn(op, m_rf[sa], m_rf[sb]);
      m_rf[dst] = r[3:0];
      m_z       = (r[3:0] == 4'd0);
      m_c       = r[4];
    end
    exp_q.push_back({dst, m_rf[dst], m_z, m_c});
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data", dbg_data, mon_e[5:2]);
        check("wb_zero", flag_zero, mon_e[1]);
        check("wb_carry", flag_carry, mon_e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic ldi, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                       input bit hold);
    logic [3:0] ea, eb, prev_a;
    @(negedge clk);
    check("ready_idle", in_if.in_ready, 1);
    ea     = m_rf[sa];
    eb     = m_rf[sb];
    prev_a = alu_a;
    in_if.in_valid = 1'b1;
    in_if.in_instr = {ldi, op, dst, sa, sb};
    in_if.in_imm   = imm;
    dbg_addr       = dst;
    push_exp(ldi, op, dst, sa, sb, imm);
    @(negedge clk);
    check("ready_exec", in_if.in_ready, 0);
    check("state_exec", dbg_state, 1);
    if (!ldi) begin
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
      check("alu_op", alu_op, op);
    end else begin
      check("alu_a_hold", alu_a, prev_a);
    end
    if (!hold) in_if.in_valid = 1'b0;
    @(negedge clk);
    in_if.in_valid = 1'b0;
  endtask

  task automatic sweep_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check(tag, dbg_data, m_rf[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_instr = 10'd0;
    in_if.in_imm   = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", in_if.in_ready, 1);
    check("rst_done", done, 0);
    check("rst_flags", {flag_zero, flag_carry}, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    sweep_rf("rst_rf");
    rst = 1'b0;

    // basic LDI / ADD / carry / zero
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 1'b0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, 1'b0);
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0);   // r2 = 8
    issue(1'b0, 3'd0, 2'd3, 2'd2, 2'd2, 4'd0, 1'b0);   // r3 = 0, z=1 c=1
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);   // z=1, c stays 1
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 1'b0);
    issue(1'b0, 3'd1, 2'd1, 2'd1, 2'd0, 4'd0, 1'b0);   // r1 = 3-5 = E, c=1
    issue(1'b0, 3'd6, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);   // r0 = A, c=0
    for (int k = 0; k < 4; k++)                        // random logic ops
      issue(1'b0, 3'($urandom_range(2, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'd0, 1'b0);

    // back-to-back with in_valid held high
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd1, 1'b0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd1, 1'b0);
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = {1'b0, 3'd0, 2'd0, 2'd0, 2'd1};
    dbg_addr       = 2'd0;
    for (int k = 0; k < 8; k++) begin
      check("b2b_ready", in_if.in_ready, (k % 2 == 0));
      if (k % 2 == 0) push_exp(1'b0, 3'd0, 2'd0, 2'd0, 2'd1, 4'd0);
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    check("b2b_r0", m_rf[0], 4'd5);

    // offer held through EXEC must not double-accept
    issue(1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 4'd0, 1'b1);   // r3 = 6
    repeat (3) @(negedge clk);
    issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd8, 1'b0);
    sweep_rf("sweep_rf");

    // async reset during EXEC aborts the writeback
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 1'b0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, 1'b0);
    issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd0, 1'b0);
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = {1'b0, 3'd0, 2'd2, 2'd0, 2'd1};
    dbg_addr       = 2'd0;
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    check("abort_alu_a_pre", alu_a, 4'd5);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", in_if.in_ready, 1);
    check("abort_state", dbg_state, 0);
    check("abort_alu", {alu_a, alu_b, alu_op}, 0);
    check("abort_done", done, 0);
    check("abort_rf0", dbg_data, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_done_after", done, 0);
    sweep_rf("abort_rf");

    // reset while in_valid is offered: no accept
    @(negedge clk);
    rst            = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_instr = {1'b1, 3'd0, 2'd1, 2'd0, 2'd0};
    in_if.in_imm   = 4'd7;
    @(negedge clk);
    check("rstvalid_state", dbg_state, 0);
    check("rstvalid_done", done, 0);
    in_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sweep_rf("rstvalid_rf");

    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7, 1'b0);
    issue(1'b0, 3'd5, 2'd2, 2'd1, 2'd1, 4'd0, 1'b0);   // r2 = ~7 = 8
    repeat (3) @(negedge clk);
    sweep_rf("final_rf");
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
